mpw_design_mux: RTL and testbench

Parametrised N-way design selector between the user-area GPIO pads and several co-resident top-level design macros. Exactly one design at a time owns `io_out`/`io_oeb`, and inactive designs are held in reset. Switching runs a guarded sequence: pads tri-stated, new design reset, then handover. It sits directly in the user project wrapper, driven by logic-analyzer bits, and replaces hard-wired single-design pad assignment.

---
 rtl/mpw_design_mux_pkg.sv | 21 ++
 rtl/mpw_io_select.sv | 35 +++
 rtl/mpw_design_mux.sv | 170 +++++++++++++++++
 tb/tb_mpw_design_mux.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mpw_design_mux_pkg.sv
// Shared types and default constants for the MPW design selector.
package mpw_design_mux_pkg;

  // Default sequencing lengths and pad count.
  localparam int unsigned DEF_GUARD_CYCLES = 4;
  localparam int unsigned DEF_RESET_HOLD   = 16;
  localparam int unsigned DEF_IO_W         = 38;

  // Switch sequence states.
  typedef enum logic [1:0] {
    ST_GUARD = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2
  } mux_state_e;

  // Larger of two unsigned values, used to size the shared counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mpw_io_select.sv
// NUM_DESIGNS:1 selection of pad out/oeb slices with force-to-safe controls.
module mpw_io_select
  import mpw_design_mux_pkg::*;
#(
  parameter int unsigned NUM_DESIGNS = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned IO_W        = DEF_IO_W
) (
  input  logic [SEL_W-1:0]            sel,
  input  logic                        force_out,
  input  logic                        force_oeb,
  input  logic [NUM_DESIGNS*IO_W-1:0] design_io_out,
  input  logic [NUM_DESIGNS*IO_W-1:0] design_io_oeb,
  output logic [IO_W-1:0]             io_out_c,
  output logic [IO_W-1:0]             io_oeb_c
);

  logic [IO_W-1:0] mux_out;
  logic [IO_W-1:0] mux_oeb;

  // Pick the selected slice; an unmatched index leaves pads tri-stated.
  always_comb begin
    mux_out = '0;
    mux_oeb = '1;
    for (int k = 0; k < int'(NUM_DESIGNS); k++) begin
      if (sel == SEL_W'(k)) begin
        mux_out = design_io_out[k*IO_W +: IO_W];
        mux_oeb = design_io_oeb[k*IO_W +: IO_W];
      end
    end
    io_out_c = force_out ? '0 : mux_out;
    io_oeb_c = force_oeb ? '1 : mux_oeb;
  end

endmodule

// File: rtl/mpw_design_mux.sv
// N-way selector attaching one design macro at a time to the user pads,
// with a guarded tri-state / reset / handover sequence on every switch.
// Optional feature: define MPW_DESIGN_MUX_OUTREG_EN to register o_io_out/o_io_oeb.
module mpw_design_mux
  import mpw_design_mux_pkg::*;
#(
  parameter int unsigned NUM_DESIGNS  = 4,
  parameter int unsigned SEL_W        = $clog2(NUM_DESIGNS),
  parameter int unsigned IO_W         = DEF_IO_W,
  parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int unsigned RESET_HOLD   = DEF_RESET_HOLD
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [SEL_W-1:0]            i_sel_req,
  input  logic                        i_sel_strobe,
  output logic [SEL_W-1:0]            o_sel_active,
  output logic                        o_busy,
  output logic                        o_sel_err,
  output logic [NUM_DESIGNS-1:0]      o_design_reset,
  input  logic [NUM_DESIGNS*IO_W-1:0] i_design_io_out,
  input  logic [NUM_DESIGNS*IO_W-1:0] i_design_io_oeb,
  output logic [IO_W-1:0]             o_io_out,
  output logic [IO_W-1:0]             o_io_oeb
);

  localparam int unsigned CNT_MAX = max_u(GUARD_CYCLES, RESET_HOLD);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SELX_W  = SEL_W + 1;
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_HOLD - 1);

  mux_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]       target_q, target_d;
  logic [SEL_W-1:0]       sel_active_d;
  logic                   busy_d;
  logic                   sel_err_d;
  logic [NUM_DESIGNS-1:0] design_reset_d;
  logic                   in_range_c;
  logic                   force_out_c;
  logic                   force_oeb_c;
  logic [IO_W-1:0]        sel_out_c;
  logic [IO_W-1:0]        sel_oeb_c;

  // Request range check; only a non-power-of-two design count can overflow.
  if ((1 << SEL_W) == NUM_DESIGNS) begin : g_pow2
    assign in_range_c = 1'b1;
  end else begin : g_npow2
    assign in_range_c = ({1'b0, i_sel_req} < SELX_W'(NUM_DESIGNS));
  end

  // Next-state, counter and registered-output values for the switch sequence.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    target_d       = target_q;
    sel_err_d      = 1'b0;
    sel_active_d   = o_sel_active;
    busy_d         = 1'b1;
    design_reset_d = '1;

    case (state_q)
      ST_GUARD: begin
        if (cnt_q == '0) begin
          state_d = ST_RESET;
          cnt_d   = RESET_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESET: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (i_sel_strobe) begin
          if (in_range_c) begin
            target_d = i_sel_req;
            state_d  = ST_GUARD;
            cnt_d    = GUARD_LOAD;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_RESET;
        cnt_d    = RESET_LOAD;
        target_d = '0;
      end
    endcase

    // Active index follows the target only once the sequence reaches RESET.
    if (state_d == ST_RESET) begin
      sel_active_d = target_d;
    end
    busy_d = (state_d != ST_RUN);
    if (state_d == ST_RUN) begin
      for (int k = 0; k < int'(NUM_DESIGNS); k++) begin
        if (sel_active_d == SEL_W'(k)) begin
          design_reset_d[k] = 1'b0;
        end
      end
    end
  end

  // State, counter and control-output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= ST_RESET;
      cnt_q          <= RESET_LOAD;
      target_q       <= '0;
      o_sel_active   <= '0;
      o_busy         <= 1'b1;
      o_sel_err      <= 1'b0;
      o_design_reset <= '1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      target_q       <= target_d;
      o_sel_active   <= sel_active_d;
      o_busy         <= busy_d;
      o_sel_err      <= sel_err_d;
      o_design_reset <= design_reset_d;
    end
  end

  mpw_io_select #(
    .NUM_DESIGNS (NUM_DESIGNS),
    .SEL_W       (SEL_W),
    .IO_W        (IO_W)
  ) u_io_select (
    .sel           (o_sel_active),
    .force_out     (force_out_c),
    .force_oeb     (force_oeb_c),
    .design_io_out (i_design_io_out),
    .design_io_oeb (i_design_io_oeb),
    .io_out_c      (sel_out_c),
    .io_oeb_c      (sel_oeb_c)
  );

`ifdef MPW_DESIGN_MUX_OUTREG_EN
  // Registered pads lag a cycle, so oeb forcing starts on the accept cycle.
  assign force_out_c = (state_q != ST_RUN);
  assign force_oeb_c = (state_q != ST_RUN) || (state_d == ST_GUARD);

  // Pad output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_io_out <= '0;
      o_io_oeb <= '1;
    end else begin
      o_io_out <= sel_out_c;
      o_io_oeb <= sel_oeb_c;
    end
  end
`else
  // Pads are a direct mux of the active design, forced safe outside RUN.
  assign force_out_c = (state_q != ST_RUN);
  assign force_oeb_c = (state_q != ST_RUN);
  assign o_io_out    = sel_out_c;
  assign o_io_oeb    = sel_oeb_c;
`endif

endmodule

// File: tb/tb_mpw_design_mux.sv
// Directed bench for mpw_design_mux: a 4-design instance for sequencing and
// a 3-design instance for out-of-range rejection.
module tb_mpw_design_mux;

  localparam int unsigned N    = 4;
  localparam int unsigned IO_W = 38;
  localparam int unsigned G    = 4;
  localparam int unsigned R    = 16;

  localparam int unsigned N3  = 3;
  localparam int unsigned IO3 = 8;
  localparam int unsigned G3  = 2;
  localparam int unsigned R3  = 3;

  localparam logic [37:0] ALL1   = 38'h3F_FFFF_FFFF;
  localparam logic [37:0] D0_OUT = 38'h3F_FFFF_FFFF;
  localparam logic [37:0] D0_OEB = 38'h00_0000_0000;
  localparam logic [37:0] D1_OUT = 38'h15_5555_5555;
  localparam logic [37:0] D1_OEB = 38'h2A_AAAA_AAAA;
  localparam logic [37:0] D2_OUT = 38'h12_3456_789A;
  localparam logic [37:0] D2_OEB = 38'h00_FFFF_0000;
  localparam logic [37:0] D3_OUT = 38'h3F_0000_FFFF;
  localparam logic [37:0] D3_OEB = 38'h0A_5A5A_5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [1:0]           sel_req;
  logic                 strobe;
  logic [1:0]           sel_active;
  logic                 busy;
  logic                 sel_err;
  logic [N-1:0]         drst;
  logic [N*IO_W-1:0]    d_out;
  logic [N*IO_W-1:0]    d_oeb;
  logic [IO_W-1:0]      io_out;
  logic [IO_W-1:0]      io_oeb;

  logic                 rst3;
  logic [1:0]           sel_req3;
  logic                 strobe3;
  logic [1:0]           sel_active3;
  logic                 busy3;
  logic                 sel_err3;
  logic [N3-1:0]        drst3;
  logic [N3*IO3-1:0]    d_out3;
  logic [N3*IO3-1:0]    d_oeb3;
  logic [IO3-1:0]       io_out3;
  logic [IO3-1:0]       io_oeb3;

  mpw_design_mux #(
    .NUM_DESIGNS (N), .IO_W (IO_W), .GUARD_CYCLES (G), .RESET_HOLD (R)
  ) dut (
    .i_clk (clk), .i_reset (rst), .i_sel_req (sel_req), .i_sel_strobe (strobe),
    .o_sel_active (sel_active), .o_busy (busy), .o_sel_err (sel_err),
    .o_design_reset (drst), .i_design_io_out (d_out), .i_design_io_oeb (d_oeb),
    .o_io_out (io_out), .o_io_oeb (io_oeb)
  );

  mpw_design_mux #(
    .NUM_DESIGNS (N3), .IO_W (IO3), .GUARD_CYCLES (G3), .RESET_HOLD (R3)
  ) dut3 (
    .i_clk (clk), .i_reset (rst3), .i_sel_req (sel_req3), .i_sel_strobe (strobe3),
    .o_sel_active (sel_active3), .o_busy (busy3), .o_sel_err (sel_err3),
    .o_design_reset (drst3), .i_design_io_out (d_out3), .i_design_io_oeb (d_oeb3),
    .o_io_out (io_out3), .o_io_oeb (io_oeb3)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  prev;
    logic [3:0]  mask;
    logic [37:0] out;
    logic [37:0] oeb;
  } vec_t;

  vec_t vecs [5];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_switch(input logic [1:0] s);
    sel_req = s;
    strobe  = 1'b1;
    step();
    strobe  = 1'b0;
  endtask

  initial begin
    int rst_hi;
    logic err_seen;

    rst = 1'b1; strobe = 1'b0; sel_req = '0;
    rst3 = 1'b1; strobe3 = 1'b0; sel_req3 = '0;
    d_out  = {D3_OUT, D2_OUT, D1_OUT, D0_OUT};
    d_oeb  = {D3_OEB, D2_OEB, D1_OEB, D0_OEB};
    d_out3 = {8'h81, 8'h3C, 8'hA5};
    d_oeb3 = {8'h00, 8'hF0, 8'h0F};

    vecs[0] = '{sel: 2'd2, prev: 2'd0, mask: 4'b1011, out: D2_OUT, oeb: D2_OEB};
    vecs[1] = '{sel: 2'd1, prev: 2'd2, mask: 4'b1101, out: D1_OUT, oeb: D1_OEB};
    vecs[2] = '{sel: 2'd1, prev: 2'd1, mask: 4'b1101, out: D1_OUT, oeb: D1_OEB};
    vecs[3] = '{sel: 2'd3, prev: 2'd1, mask: 4'b0111, out: D3_OUT, oeb: D3_OEB};
    vecs[4] = '{sel: 2'd0, prev: 2'd3, mask: 4'b1110, out: D0_OUT, oeb: D0_OEB};

    // Reset state.
    repeat (2) step();
    check("rst_active", sel_active, 2'd0);
    check("rst_busy", busy, 1'b1);
    check("rst_err", sel_err, 1'b0);
    check("rst_drst", drst, 4'hF);
    check("rst_oeb", io_oeb, ALL1);
    check("rst_out", io_out, 38'h0);

    // Reset release: RESET_HOLD edges to RUN.
    rst = 1'b0;
    check("rel0_oeb", io_oeb, ALL1);
    repeat (R - 1) step();
    check("rel15_oeb", io_oeb, ALL1);
    check("rel15_busy", busy, 1'b1);
    step();
    check("rel16_oeb", io_oeb, D0_OEB);
    check("rel16_out", io_out, D0_OUT);
    check("rel16_drst", drst, 4'b1110);
    check("rel16_busy", busy, 1'b0);

    // Table-driven switch sequences.
    for (int i = 0; i < 5; i++) begin
      do_switch(vecs[i].sel);
      rst_hi   = 0;
      err_seen = 1'b0;
      for (int m = 0; m <= int'(G + R); m++) begin
        if (m == 0) begin
          check("sw_m0_busy", busy, 1'b1);
          check("sw_m0_oeb", io_oeb, ALL1);
          check("sw_m0_out", io_out, 38'h0);
          check("sw_m0_active", sel_active, vecs[i].prev);
          check("sw_m0_drst", drst, 4'hF);
        end
        if (m == int'(G) - 1) check("sw_guard_end_active", sel_active, vecs[i].prev);
        if (m == int'(G)) begin
          check("sw_reset_active", sel_active, vecs[i].sel);
          check("sw_reset_oeb", io_oeb, ALL1);
        end
        if (m == int'(G + R) - 1) check("sw_reset_end_busy", busy, 1'b1);
        if (m < int'(G + R) && drst[vecs[i].sel]) rst_hi++;
        err_seen = err_seen | sel_err;
        if (m == int'(G + R)) begin
          check("sw_run_busy", busy, 1'b0);
          check("sw_run_active", sel_active, vecs[i].sel);
          check("sw_run_out", io_out, vecs[i].out);
          check("sw_run_oeb", io_oeb, vecs[i].oeb);
          check("sw_run_drst", drst, vecs[i].mask);
        end else begin
          step();
        end
      end
      check("sw_target_reset_cycles", rst_hi, G + R);
      check("sw_no_err", err_seen, 1'b0);
    end

    // Strobe while busy is ignored.
    do_switch(2'd1);
    err_seen = 1'b0;
    for (int m = 0; m < int'(G + R); m++) begin
      if (m == int'(G) + 2) begin
        sel_req = 2'd3;
        strobe  = 1'b1;
      end
      err_seen = err_seen | sel_err;
      step();
      strobe = 1'b0;
    end
    check("busy_strobe_active", sel_active, 2'd1);
    check("busy_strobe_busy", busy, 1'b0);
    check("busy_strobe_err", err_seen, 1'b0);
    check("busy_strobe_oeb", io_oeb, D1_OEB);

    // Reset asserted in cycle 2 of a switch to design 3.
    do_switch(2'd3);
    step();
    rst = 1'b1;
    #1;
    check("midrst_active", sel_active, 2'd0);
    check("midrst_busy", busy, 1'b1);
    check("midrst_drst", drst, 4'hF);
    check("midrst_oeb", io_oeb, ALL1);
    check("midrst_out", io_out, 38'h0);
    check("midrst_err", sel_err, 1'b0);
    step();
    rst = 1'b0;
    repeat (R - 1) step();
    check("midrst_rel15_busy", busy, 1'b1);
    step();
    check("midrst_rel16_busy", busy, 1'b0);
    check("midrst_rel16_active", sel_active, 2'd0);
    check("midrst_rel16_out", io_out, D0_OUT);
    check("midrst_rel16_oeb", io_oeb, D0_OEB);
    check("midrst_rel16_drst", drst, 4'b1110);

    // Three-design instance: release, out-of-range reject, valid switch.
    step();
    check("n3_rst_busy", busy3, 1'b1);
    rst3 = 1'b0;
    repeat (R3 - 1) step();
    check("n3_rel_pre_busy", busy3, 1'b1);
    step();
    check("n3_rel_busy", busy3, 1'b0);
    check("n3_rel_out", io_out3, 8'hA5);
    check("n3_rel_oeb", io_oeb3, 8'h0F);
    check("n3_rel_drst", drst3, 3'b110);

    sel_req3 = 2'd3;
    strobe3  = 1'b1;
    step();
    strobe3  = 1'b0;
    check("n3_oor_err", sel_err3, 1'b1);
    check("n3_oor_busy", busy3, 1'b0);
    check("n3_oor_active", sel_active3, 2'd0);
    check("n3_oor_out", io_out3, 8'hA5);
    step();
    check("n3_oor_err_clear", sel_err3, 1'b0);
    check("n3_oor_busy2", busy3, 1'b0);
    check("n3_oor_oeb", io_oeb3, 8'h0F);

    sel_req3 = 2'd2;
    strobe3  = 1'b1;
    step();
    strobe3  = 1'b0;
    check("n3_sw_busy", busy3, 1'b1);
    check("n3_sw_oeb", io_oeb3, 8'hFF);
    repeat (G3 + R3) step();
    check("n3_sw_run_busy", busy3, 1'b0);
    check("n3_sw_run_active", sel_active3, 2'd2);
    check("n3_sw_run_out", io_out3, 8'h81);
    check("n3_sw_run_oeb", io_oeb3, 8'h00);
    check("n3_sw_run_drst", drst3, 3'b011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
